// File: rtl/mem_rd_resp_mc.sv
// mem_rd_resp_mc: multi-channel line-memory responder with round-robin reads, masked burst writes and backdoor load
// Ports: rd_req/rd_start_addr/rd_size_bytes per-channel read requests (flattened, channel 0 in the low slice);
//   rd_valid/rd_last one-hot beat strobes with shared rd_data and rd_last_valid (index of last valid word);
//   wr_req/wr_start_addr/wr_size_bytes/wr_data one-line-per-wr_ack write burst; ld_en/ld_addr/ld_data
//   backdoor line load with priority over burst writes; busy high whenever the FSM is not idle.
module mem_rd_resp_mc #(
  parameter int NUM_CH            = 3,
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH        = 19,
  parameter int MEM_DEPTH_LINES   = 4096,
  parameter int SIZE_WIDTH        = 16,
  parameter int RD_LATENCY        = 2,
  parameter int BEAT_GAP          = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH-1:0]                       rd_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]            rd_start_addr,
  input  logic [NUM_CH*SIZE_WIDTH-1:0]            rd_size_bytes,
  output logic [NUM_CH-1:0]                       rd_valid,
  output logic [NUM_CH-1:0]                       rd_last,
  output logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] rd_data,
  output logic [$clog2(NUM_WORDS_IN_LINE)-1:0]    rd_last_valid,
  input  logic                                    wr_req,
  input  logic [ADDR_WIDTH-1:0]                   wr_start_addr,
  input  logic [SIZE_WIDTH-1:0]                   wr_size_bytes,
  input  logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] wr_data,
  output logic                                    wr_ack,
  input  logic                                    ld_en,
  input  logic [$clog2(MEM_DEPTH_LINES)-1:0]      ld_addr,
  input  logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] ld_data,
  output logic                                    busy
);
  localparam int LINE_W = WORD_WIDTH*NUM_WORDS_IN_LINE;
  localparam int LB = $clog2(LINE_W/8);
  localparam int LVW = $clog2(NUM_WORDS_IN_LINE);
  localparam int DW = $clog2(MEM_DEPTH_LINES);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [SIZE_WIDTH-1:0] ONE = 1;
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, LAT = 3'd2, BURST = 3'd3, WRITE = 3'd4;
  logic [LINE_W-1:0] mem [MEM_DEPTH_LINES];
  logic [2:0] state;
  logic [7:0] cnt;
  logic [SIZE_WIDTH-1:0] rem, s_size, s_eff, s_m1, s_n, f_rem;
  logic [DW-1:0] line, s_line, f_line;
  logic [LVW-1:0] lastv, s_lastv, f_lastv;
  logic [CHW-1:0] ch, rr, sel, off, f_ch;
  logic [CHW:0] sum;
  logic [NUM_CH-1:0] rot;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic arb_rd, fire, wr_do;
  // rotate requests so bit 0 is the channel right after the last grant
  assign rot = NUM_CH'({rd_req, rd_req} >> rr);
  always_comb begin
    off = '0;
    for (int i = NUM_CH-1; i >= 0; i--) if (rot[i]) off = CHW'(i);
    sum = {1'b0, rr} + {1'b0, off};
    sel = (sum >= (CHW+1)'(NUM_CH)) ? CHW'(sum - (CHW+1)'(NUM_CH)) : CHW'(sum);
  end
  assign s_addr  = wr_req ? wr_start_addr : rd_start_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_size  = wr_req ? wr_size_bytes : rd_size_bytes[sel*SIZE_WIDTH +: SIZE_WIDTH];
  assign s_eff   = (s_size == '0) ? ONE : s_size;
  assign s_m1    = s_eff - ONE;
  assign s_n     = (s_m1 >> LB) + ONE;
  assign s_lastv = LVW'(s_m1);
  assign s_line  = DW'(s_addr >> LB);
  assign arb_rd  = state == ARB && !wr_req && |rd_req;
  // beat source: straight from the arbiter when RD_LATENCY==1 fires in ARB, otherwise from the burst registers
  assign f_ch    = (state == ARB) ? sel : ch;
  assign f_line  = (state == ARB) ? s_line : line;
  assign f_rem   = (state == ARB) ? s_n : rem;
  assign f_lastv = (state == ARB) ? s_lastv : lastv;
  assign fire    = (arb_rd && RD_LATENCY == 1) || ((state == LAT || state == BURST) && cnt == '0 && rem != '0);
  // cnt!=0 in WRITE marks the ack cycle, during which the requester swaps in its next line
  assign wr_do   = state == WRITE && cnt == '0 && rem != '0 && !ld_en;
  assign busy    = state != IDLE;
  always_ff @(posedge clk)
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_do)
      for (int i = 0; i < NUM_WORDS_IN_LINE; i++)
        if (rem != ONE || i <= int'(lastv)) mem[line][i*WORD_WIDTH +: WORD_WIDTH] <= wr_data[i*WORD_WIDTH +: WORD_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      line <= '0;
      lastv <= '0;
      ch <= '0;
      rr <= '0;
      rd_valid <= '0;
      rd_last <= '0;
      rd_data <= '0;
      rd_last_valid <= '0;
      wr_ack <= 1'b0;
    end else begin
      rd_valid <= fire ? NUM_CH'(1) << f_ch : '0;
      rd_last <= (fire && f_rem == ONE) ? NUM_CH'(1) << f_ch : '0;
      wr_ack <= wr_do;
      if (fire) begin
        rd_data <= mem[f_line];
        rd_last_valid <= (f_rem == ONE) ? f_lastv : LVW'(NUM_WORDS_IN_LINE-1);
      end
      case (state)
        IDLE: state <= (|rd_req || wr_req) ? ARB : IDLE;
        ARB: begin
          line <= s_line;
          lastv <= s_lastv;
          rem <= s_n;
          ch <= sel;
          cnt <= '0;
          if (wr_req) state <= WRITE;
          else if (|rd_req) begin
            rr <= (sel == CHW'(NUM_CH-1)) ? '0 : sel + CHW'(1);
            if (RD_LATENCY == 1) begin
              state <= BURST;
              line <= s_line + DW'(1);
              rem <= s_n - ONE;
              cnt <= 8'(BEAT_GAP);
            end else begin
              state <= LAT;
              cnt <= 8'(RD_LATENCY-2);
            end
          end else state <= IDLE;
        end
        LAT, BURST:
          if (state == BURST && rem == '0) state <= IDLE;
          else if (fire) begin
            rem <= rem - ONE;
            line <= line + DW'(1);
            cnt <= 8'(BEAT_GAP);
            state <= BURST;
          end else cnt <= cnt - 8'd1;
        WRITE:
          if (wr_do) begin
            rem <= rem - ONE;
            line <= line + DW'(1);
            cnt <= 8'd1;
          end else if (cnt != '0) begin
            cnt <= '0;
            state <= (rem == '0) ? IDLE : WRITE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
